// File: rtl/sha3_result_collector.sv
// Result FIFO behind the SHA3 scanner: captures hit pulses (nonce + leading digest words)
// so the register front-end can drain them at its own pace, with saturating hit/drop counters.
module sha3_result_collector #(
  parameter int DEPTH        = 4,
  parameter int DIGEST_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     capture,
  input  logic [31:0]              nonce,
  input  logic [63:0]              hash [25],
  input  logic                     flush,
  input  logic                     rready,
  output logic                     rvalid,
  output logic [31:0]              rnonce,
  output logic [63:0]              rdigest [DIGEST_WORDS],
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [31:0]              found_count,
  output logic [15:0]              dropped_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   found_q, found_d;
  logic [15:0]   dropped_q, dropped_d;
  logic [31:0]   mem_nonce_q [DEPTH];
  logic [31:0]   mem_nonce_d [DEPTH];
  logic [63:0]   mem_dig_q [DEPTH][DIGEST_WORDS];
  logic [63:0]   mem_dig_d [DEPTH][DIGEST_WORDS];

  logic is_full, is_empty, pop, push, drop;
  logic unused_hash;

  assign is_full  = (level_q == LW'(DEPTH));
  assign is_empty = (level_q == '0);
  assign pop      = !is_empty && rready;
  assign push     = capture && (!is_full || pop);
  assign drop     = capture && is_full && !pop;

  always_comb begin
    unused_hash = 1'b0;
    for (int w = DIGEST_WORDS; w < 25; w++) unused_hash = unused_hash ^ (^hash[w]);
  end

  // Flush overrides any coincident push, pop or drop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    found_d     = found_q;
    dropped_d   = dropped_q;
    mem_nonce_d = mem_nonce_q;
    mem_dig_d   = mem_dig_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      found_d   = '0;
      dropped_d = '0;
    end else begin
      if (push) begin
        mem_nonce_d[wr_ptr_q] = nonce;
        for (int w = 0; w < DIGEST_WORDS; w++) mem_dig_d[wr_ptr_q][w] = hash[w];
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (found_q != '1) found_d = found_q + 32'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (drop && dropped_q != '1) dropped_d = dropped_q + 16'd1;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      found_q   <= '0;
      dropped_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      found_q   <= found_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_nonce_q <= mem_nonce_d;
    mem_dig_q   <= mem_dig_d;
  end

  // Head data is masked while empty so uninitialised storage never shows as X.
  always_comb begin
    rnonce = is_empty ? 32'd0 : mem_nonce_q[rd_ptr_q];
    for (int w = 0; w < DIGEST_WORDS; w++)
      rdigest[w] = is_empty ? 64'd0 : mem_dig_q[rd_ptr_q][w];
  end

  assign rvalid        = !is_empty;
  assign level         = level_q;
  assign full          = is_full;
  assign found_count   = found_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_sha3_result_collector.sv
// Randomised and directed bench for sha3_result_collector, checked every cycle
// against a queue-based reference model of the result FIFO.
module tb_sha3_result_collector;

  localparam int DEPTH = 4;
  localparam int DW    = 4;

  typedef struct packed {
    logic [31:0]      nonce;
    logic [DW*64-1:0] dig;
  } entry_t;

  logic        clk = 1'b0;
  logic        rstn, capture, flush, rready;
  logic [31:0] nonce;
  logic [63:0] hash [25];
  logic        rvalid, full;
  logic [31:0] rnonce, found_count;
  logic [63:0] rdigest [DW];
  logic [2:0]  level;
  logic [15:0] dropped_count;

  entry_t      model_q [$];
  int unsigned model_found;
  int unsigned model_dropped;
  int          checks = 0;
  int          errors = 0;

  sha3_result_collector #(.DEPTH(DEPTH), .DIGEST_WORDS(DW)) dut (
    .clk(clk), .rstn(rstn), .capture(capture), .nonce(nonce), .hash(hash),
    .flush(flush), .rready(rready), .rvalid(rvalid), .rnonce(rnonce),
    .rdigest(rdigest), .level(level), .full(full),
    .found_count(found_count), .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: reset, then flush, then pop-before-push on a plain queue.
  task automatic model_update();
    entry_t e;
    bit     popm;
    if (!rstn || flush) begin
      model_q.delete();
      model_found   = 0;
      model_dropped = 0;
    end else begin
      popm = (model_q.size() > 0) && rready;
      if (popm) void'(model_q.pop_front());
      if (capture) begin
        if (model_q.size() < DEPTH) begin
          e.nonce = nonce;
          for (int w = 0; w < DW; w++) e.dig[w*64 +: 64] = hash[w];
          model_q.push_back(e);
          if (model_found != 32'hFFFF_FFFF) model_found++;
        end else if (model_dropped != 16'hFFFF) begin
          model_dropped++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_output("rvalid", rvalid, model_q.size() != 0);
    check_output("level", level, model_q.size());
    check_output("full", full, model_q.size() == DEPTH);
    check_output("found", found_count, model_found);
    check_output("dropped", dropped_count, model_dropped);
    check_output("rnonce_known", $isunknown(rnonce), 0);
    if (model_q.size() != 0) begin
      check_output("rnonce", rnonce, model_q[0].nonce);
      for (int w = 0; w < DW; w++)
        check_output("rdigest", rdigest[w], model_q[0].dig[w*64 +: 64]);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic apply_stimulus(input logic cap, input logic [31:0] n, input logic rdy, input logic fl);
    capture = cap;
    nonce   = n;
    rready  = rdy;
    flush   = fl;
    for (int w = 0; w < 25; w++) hash[w] = {$urandom, $urandom};
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    capture = 1'b0; flush = 1'b0; rready = 1'b0; nonce = '0;
    for (int w = 0; w < 25; w++) hash[w] = '0;

    // Reset then idle
    tick(); tick();
    check_output("reset_level", level, 0);
    check_output("reset_found", found_count, 0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);

    // Single hit with a known leading digest word
    capture = 1'b1; nonce = 32'h0000_1234; rready = 1'b0; flush = 1'b0;
    for (int w = 0; w < 25; w++) hash[w] = {$urandom, $urandom};
    hash[0] = 64'hDEAD_BEEF_0000_0001;
    tick();
    check_output("single_rnonce", rnonce, 32'h1234);
    check_output("single_digest0", rdigest[0], 64'hDEAD_BEEF_0000_0001);
    check_output("single_found", found_count, 1);
    apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
    check_output("single_drained", rvalid, 0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);

    // Burst overflow
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) apply_stimulus(1'b1, i, 1'b0, 1'b0);
    check_output("burst_level", level, 4);
    check_output("burst_full", full, 1);
    check_output("burst_found", found_count, 4);
    check_output("burst_dropped", dropped_count, 2);
    for (int i = 1; i <= 4; i++) begin
      check_output("burst_order", rnonce, i);
      apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
    end

    // Full with simultaneous push and pop
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 10; i <= 13; i++) apply_stimulus(1'b1, i, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'd14, 1'b1, 1'b0);
    check_output("pushpop_level", level, 4);
    check_output("pushpop_dropped", dropped_count, 0);
    for (int i = 11; i <= 14; i++) begin
      check_output("pushpop_order", rnonce, i);
      apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
    end

    // Pointer wrap with continuous draining
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3*DEPTH+1; i++) apply_stimulus(1'b1, 32'h100 + i, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
    check_output("wrap_found", found_count, 13);
    check_output("wrap_dropped", dropped_count, 0);

    // Flush against capture, then reset mid-burst
    apply_stimulus(1'b1, 32'h21, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h22, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h99, 1'b1, 1'b1);
    check_output("flush_rvalid", rvalid, 0);
    check_output("flush_found", found_count, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 32'h200 + i, 1'b0, 1'b0);
    rstn = 1'b0;
    apply_stimulus(1'b1, 32'h2FF, 1'b0, 1'b0);
    rstn = 1'b1;
    check_output("midreset_level", level, 0);
    check_output("midreset_dropped", dropped_count, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      apply_stimulus($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1),
                     $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
